// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-cycle wide add/subtract that streams 32-bit words through an external carry slice

// Reference 32-bit adder slice with carry in/out.
module add_with_carry_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module wide_add_sequencer #(
  parameter int NWORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [32*NWORDS-1:0]  op_a,
  input  logic [32*NWORDS-1:0]  op_b,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_cin,
  input  logic [31:0]           add_sum,
  input  logic                  add_cout,
  output logic                  busy,
  output logic                  done,
  output logic [32*NWORDS-1:0]  result,
  output logic                  cout
);
  localparam int KW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NWORDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [NWORDS-1:0][31:0] a_q, b_q, res_q;
  logic sub_q, carry, accept, last;
  logic [KW-1:0] k;
  assign busy    = state == RUN;
  assign done    = state == DONE;
  assign result  = res_q;
  assign add_a   = busy ? a_q[k] : '0;
  assign add_b   = busy ? b_q[k] ^ {32{sub_q}} : '0;
  assign add_cin = busy & carry;
  // Start is honoured only between operations; the last word hands over to DONE.
  always_comb begin
    accept   = start && (state == IDLE || state == DONE);
    last     = busy && k == KLAST;
    state_nx = accept ? RUN : last ? DONE : busy ? RUN : IDLE;
  end
  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Operand latch on accept, then one result word and carry per RUN cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      carry <= 1'b0;
      res_q <= '0;
      k     <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_q   <= op_a;
      b_q   <= op_b;
      sub_q <= sub;
      carry <= sub | cin;
      res_q <= '0;
      k     <= '0;
    end else if (busy) begin
      res_q[k] <= add_sum;
      carry    <= add_cout;
      k        <= last ? '0 : k + KW'(1);
      if (last) cout <= add_cout;
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed vectors with a queue-based scoreboard for wide_add_sequencer
module tb_wide_add_sequencer;
  localparam int NW = 4;
  localparam int W = 32 * NW;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [31:0] add_a, add_b, add_sum;
  logic add_cin, add_cout, busy, done, cout;
  logic [W-1:0] result;
  int checks = 0, failures = 0;
  logic [W:0] expq[$];

  always #5 clk = ~clk;

  add_with_carry_32bit slice (
    .a(add_a), .b(add_b), .cin(add_cin), .sum(add_sum), .cout(add_cout)
  );

  wide_add_sequencer #(.NWORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .op_a(op_a), .op_b(op_b), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .busy(busy), .done(done),
    .result(result), .cout(cout)
  );

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk)
    if (done) begin
      if (expq.size() == 0) chk("done_without_request", (W+1)'(done), '0);
      else chk("result_cout", {cout, result}, expq.pop_front());
    end

  // Issue one operation from the current negedge and time its done pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic c, input logic [W:0] exp, input bit poke);
    int nb, at;
    bit seen;
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    expq.push_back(exp);
    @(posedge clk);
    #1 start = 1'b0;
    nb = 0; at = 0; seen = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (poke && n == 2) begin
        start = 1'b1; op_a = ~a; op_b = b + 1; sub = ~s;
      end
      if (poke && n == 3) start = 1'b0;
      if (busy) nb++;
      if (done) begin
        seen = 1'b1;
        at = n;
      end
    end
    chk("done_seen", (W+1)'(seen), (W+1)'(1));
    if (seen) begin
      chk("done_latency", (W+1)'(at), (W+1)'(5));
      chk("busy_cycles", (W+1)'(nb), (W+1)'(4));
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(negedge clk);
      if (done) n = i;
    end
    chk("done_seen_b2b", (W+1)'(n != 0), (W+1)'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    #12;
    chk("reset_result", {cout, result}, '0);
    chk("reset_status", (W+1)'({busy, done, add_cin}), '0);
    chk("reset_adder_drive", (W+1)'({add_a, add_b}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op({W{1'b1}}, W'(1), 1'b0, 1'b0, {1'b1, {W{1'b0}}}, 1'b0);
    @(negedge clk);
    run_op(W'(32'hFFFF_FFFF), W'(1), 1'b0, 1'b0, {1'b0, W'(64'h1_0000_0000)}, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_in_idle", {cout, result}, {1'b0, W'(64'h1_0000_0000)});
    chk("idle_adder_drive", (W+1)'({add_a, add_b, add_cin}), '0);
    @(negedge clk);
    run_op(W'(7), W'(5), 1'b1, 1'b0, {1'b1, W'(2)}, 1'b0);
    @(negedge clk);
    run_op(W'(5), W'(7), 1'b1, 1'b0, {1'b0, {{(W-2){1'b1}}, 2'b10}}, 1'b0);
    @(negedge clk);
    run_op(W'(7), W'(5), 1'b1, 1'b1, {1'b1, W'(2)}, 1'b0);
    @(negedge clk);
    run_op(128'h80000000_00000000_FFFFFFFF_12345678, 128'h80000000_00000000_00000001_EDCBA988,
           1'b0, 1'b0, {1'b1, 128'h00000000_00000001_00000001_00000000}, 1'b0);
    @(negedge clk);
    run_op('0, '0, 1'b0, 1'b1, {1'b0, W'(1)}, 1'b1);
    // Abort mid-operation: two words captured, then asynchronous reset.
    @(negedge clk);
    op_a = {W{1'b1}}; op_b = {W{1'b1}}; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_status", (W+1)'({busy, done}), '0);
    chk("abort_result", {cout, result}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    run_op(W'(3), W'(4), 1'b0, 1'b0, {1'b0, W'(7)}, 1'b0);
    // Back-to-back: start held high through DONE.
    @(negedge clk);
    op_a = W'(10); op_b = W'(20); sub = 1'b0; cin = 1'b0; start = 1'b1;
    expq.push_back({1'b0, W'(30)});
    @(posedge clk);
    #1;
    op_a = W'(100); op_b = W'(1); sub = 1'b1;
    expq.push_back({1'b1, W'(99)});
    wait_done(d);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("no_idle_gap", (W+1)'(busy), (W+1)'(1));
    wait_done(d);
    chk("done_spacing", (W+1)'(d + 1), (W+1)'(5));
    repeat (3) @(negedge clk);
    chk("queue_drained", (W+1)'(expq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
